// File: rtl/sprite_compositor_pkg.sv
// ---------------------------------------------------------------------------
// sprite_compositor_pkg
//   Screen geometry and colour constants shared by the sprite compositor,
//   the animation stage and the VGA timing generator.
// ---------------------------------------------------------------------------
package sprite_compositor_pkg;

  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;
  localparam int POS_BITS   = 10;
  localparam int COLOR_BITS = 12;

  // RGB444 texel value that marks a see-through sprite pixel.
  localparam logic [COLOR_BITS-1:0] TRANSPARENT_KEY = 12'hF0F;
  // Colour shown wherever no opaque sprite texel covers the beam.
  localparam logic [COLOR_BITS-1:0] BG_COLOR        = 12'h000;

endpackage

// File: rtl/sprite_hit_addr.sv
// ---------------------------------------------------------------------------
// sprite_hit_addr
//   Stages 1 and 2 of the compositor pipeline. Stage 1 tests whether the beam
//   lies inside the latched sprite rectangle and registers the offsets into
//   the sprite. Stage 2 turns the offsets into a linear sprite ROM address.
//
//   Ports:
//     i_clk, i_rst           pixel clock (negedge active), sync active-high reset
//     i_pixel_x/y            current beam position
//     i_pixel_valid          beam is in active video
//     i_latch_x/y            sprite top-left corner held for this frame
//     o_rom_addr             ROM read address, 2 cycles after the pixel
//     o_hit, o_valid         stage-2 hit / active-video flags, aligned with
//                            o_rom_addr
// ---------------------------------------------------------------------------
module sprite_hit_addr
  import sprite_compositor_pkg::*;
#(
  parameter int SPRITE_W  = 388,
  parameter int SPRITE_H  = 68,
  parameter int ADDR_BITS = 15
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [POS_BITS-1:0]  i_pixel_x,
  input  logic [POS_BITS-1:0]  i_pixel_y,
  input  logic                 i_pixel_valid,
  input  logic [POS_BITS-1:0]  i_latch_x,
  input  logic [POS_BITS-1:0]  i_latch_y,
  output logic [ADDR_BITS-1:0] o_rom_addr,
  output logic                 o_hit,
  output logic                 o_valid
);

  // One extra bit on the far-edge sums: a sprite parked near x=1023 would
  // otherwise wrap its right edge to a small value and claim a false hit.
  localparam int SUM_BITS = POS_BITS + 1;

  logic [SUM_BITS-1:0]  w_x_end;
  logic [SUM_BITS-1:0]  w_y_end;
  logic                 w_hit;
  logic [ADDR_BITS-1:0] w_addr;

  logic                 r_hit1;
  logic                 r_valid1;
  logic [POS_BITS-1:0]  r_dx1;
  logic [POS_BITS-1:0]  r_dy1;
  logic [ADDR_BITS-1:0] r_rom_addr;
  logic                 r_hit2;
  logic                 r_valid2;

  assign w_x_end = {1'b0, i_latch_x} + SUM_BITS'(SPRITE_W);
  assign w_y_end = {1'b0, i_latch_y} + SUM_BITS'(SPRITE_H);

  assign w_hit = i_pixel_valid
               && (i_pixel_x >= i_latch_x) && ({1'b0, i_pixel_x} < w_x_end)
               && (i_pixel_y >= i_latch_y) && ({1'b0, i_pixel_y} < w_y_end);

  // Multiplying at ADDR_BITS is the same as truncating the full product.
  assign w_addr = ADDR_BITS'(r_dy1) * ADDR_BITS'(SPRITE_W) + ADDR_BITS'(r_dx1);

  always_ff @(negedge i_clk) begin
    if (i_rst) begin
      r_hit1     <= 1'b0;
      r_valid1   <= 1'b0;
      r_dx1      <= '0;
      r_dy1      <= '0;
      r_rom_addr <= '0;
      r_hit2     <= 1'b0;
      r_valid2   <= 1'b0;
    end else begin
      // Stage 1: offsets are only meaningful when r_hit1 is set.
      r_hit1     <= w_hit;
      r_valid1   <= i_pixel_valid;
      r_dx1      <= i_pixel_x - i_latch_x;
      r_dy1      <= i_pixel_y - i_latch_y;
      // Stage 2: misses park the ROM on address 0.
      r_rom_addr <= r_hit1 ? w_addr : '0;
      r_hit2     <= r_hit1;
      r_valid2   <= r_valid1;
    end
  end

  assign o_rom_addr = r_rom_addr;
  assign o_hit      = r_hit2;
  assign o_valid    = r_valid2;

endmodule

// File: rtl/sprite_compositor.sv
// ---------------------------------------------------------------------------
// sprite_compositor
//   Overlays one ROM-backed sprite on the active-video pixel stream. The
//   sprite position is latched once per frame so mid-frame moves never tear.
//   Pixel in -> colour out is a fixed 3-cycle pipeline, one pixel per cycle.
//
//   Stream protocol: valid-only, no ready. pixelValid qualifies pixelX/pixelY
//   in the cycle it is high; pixelColorValid qualifies pixelColor exactly 3
//   cycles later. Nothing ever stalls.
//
//   Ports:
//     CLOCK, RESET           pixel clock (negedge active), sync active-high reset
//     spriteX/Y              sprite top-left from the animation stage
//     pixelX/Y, pixelValid   beam position from the VGA timing generator
//     frameStart             one-cycle pulse at start of vertical blank
//     romAddr / romData      sprite ROM port, data returns 1 cycle after addr
//     pixelColor(Valid)      composited RGB444 colour to the VGA output
// ---------------------------------------------------------------------------
module sprite_compositor
  import sprite_compositor_pkg::POS_BITS;
#(
  parameter int                    SPRITE_W        = 388,
  parameter int                    SPRITE_H        = 68,
  parameter int                    ADDR_BITS       = 15,
  parameter int                    COLOR_BITS      = sprite_compositor_pkg::COLOR_BITS,
  parameter logic [COLOR_BITS-1:0] TRANSPARENT_KEY = sprite_compositor_pkg::TRANSPARENT_KEY,
  parameter logic [COLOR_BITS-1:0] BG_COLOR        = sprite_compositor_pkg::BG_COLOR
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic [POS_BITS-1:0]   spriteX,
  input  logic [POS_BITS-1:0]   spriteY,
  input  logic [POS_BITS-1:0]   pixelX,
  input  logic [POS_BITS-1:0]   pixelY,
  input  logic                  pixelValid,
  input  logic                  frameStart,
  output logic [ADDR_BITS-1:0]  romAddr,
  input  logic [COLOR_BITS-1:0] romData,
  output logic [COLOR_BITS-1:0] pixelColor,
  output logic                  pixelColorValid
);

  logic [POS_BITS-1:0]   r_latch_x;
  logic [POS_BITS-1:0]   r_latch_y;
  logic [COLOR_BITS-1:0] r_color;
  logic                  r_color_valid;
  logic                  w_hit2;
  logic                  w_valid2;

  // Position latch. A pixel presented in the frameStart cycle still sees the
  // old position because stage 1 samples r_latch_* on that same edge.
  always_ff @(negedge CLOCK) begin
    if (RESET) begin
      r_latch_x <= '0;
      r_latch_y <= '0;
    end else if (frameStart) begin
      r_latch_x <= spriteX;
      r_latch_y <= spriteY;
    end
  end

  sprite_hit_addr #(
    .SPRITE_W  (SPRITE_W),
    .SPRITE_H  (SPRITE_H),
    .ADDR_BITS (ADDR_BITS)
  ) u_hit_addr (
    .i_clk         (CLOCK),
    .i_rst         (RESET),
    .i_pixel_x     (pixelX),
    .i_pixel_y     (pixelY),
    .i_pixel_valid (pixelValid),
    .i_latch_x     (r_latch_x),
    .i_latch_y     (r_latch_y),
    .o_rom_addr    (romAddr),
    .o_hit         (w_hit2),
    .o_valid       (w_valid2)
  );

  // Stage 3: romData now belongs to the address issued last cycle. Blanking
  // forces 0; inside active video, misses and transparent texels show BG.
  always_ff @(negedge CLOCK) begin
    if (RESET) begin
      r_color       <= '0;
      r_color_valid <= 1'b0;
    end else begin
      r_color_valid <= w_valid2;
      if (!w_valid2) begin
        r_color <= '0;
      end else if (w_hit2 && (romData != TRANSPARENT_KEY)) begin
        r_color <= romData;
      end else begin
        r_color <= BG_COLOR;
      end
    end
  end

  assign pixelColor      = r_color;
  assign pixelColorValid = r_color_valid;

endmodule
